// File: rtl/rfwrite_trace_checker_pkg.sv
// rfwrite_trace_checker_pkg: shared types for the register-file write trace checker.
package rfwrite_trace_checker_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       wen;
        logic [4:0] addr;
        word_t      wd;
    } rf_w_t;

    typedef enum logic [2:0] {
        CHK_NONE,
        CHK_PC,
        CHK_REG,
        CHK_DATA,
        CHK_OVERRUN,
        CHK_UNDERRUN
    } chk_fail_t;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_FIN_RD,
        ST_FIN_CMP,
        ST_DONE,
        ST_FAIL
    } chk_state_t;

endpackage

// File: rtl/rfwrite_trace_checker_cmp.sv
// rfw_trace_cmp: classifies one latched commit against its trace entry.
module rfw_trace_cmp
    import rfwrite_trace_checker_pkg::*;
(
    input  logic [4:0] addr,
    input  word_t      wd,
    input  word_t      pc,
    input  word_t      trace_pc,
    input  logic [4:0] trace_waddr,
    input  word_t      trace_wdata,
    input  logic       trace_end,
    output chk_fail_t  code
);

    assign code = trace_end               ? CHK_OVERRUN :
                  pc   != trace_pc        ? CHK_PC      :
                  addr != trace_waddr     ? CHK_REG     :
                  wd   != trace_wdata     ? CHK_DATA    : CHK_NONE;

endmodule

// File: rtl/rfwrite_trace_checker.sv
// rfwrite_trace_checker: compares the committed register-file write stream against a golden trace.
// Define RFW_CHECK_SKIP_R0_EN to drop $0 writes before they reach the trace.
module rfwrite_trace_checker
    import rfwrite_trace_checker_pkg::*;
#(
    parameter int TRACE_AW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  rf_w_t               rfw_in,
    input  word_t               pc_in,
    input  logic                finish,
    output logic                trace_ren,
    output logic [TRACE_AW-1:0] trace_raddr,
    input  word_t               trace_pc,
    input  logic [4:0]          trace_waddr,
    input  word_t               trace_wdata,
    input  logic                trace_end,
    output logic                chk_pass,
    output logic                chk_fail,
    output chk_fail_t           fail_code,
    output logic [TRACE_AW-1:0] fail_idx,
    output word_t               fail_pc,
    output word_t               fail_exp,
    output word_t               fail_got,
    output word_t               commit_cnt
);

`ifdef RFW_CHECK_SKIP_R0_EN
    localparam bit SKIP_R0 = 1'b1;
`else
    localparam bit SKIP_R0 = 1'b0;
`endif

    localparam logic [TRACE_AW-1:0] IDX_MAX = '1;

    chk_state_t          state;
    logic [TRACE_AW-1:0] idx;
    logic [TRACE_AW-1:0] s2_idx;
    logic                s2_v;
    logic [4:0]          s2_addr;
    word_t               s2_wd;
    word_t               s2_pc;
    chk_fail_t           cmp_code;
    logic                c_v;
    logic                s2_err;
    logic                late_commit;
    logic                s1_take;
    logic                fin_rd;

    rfw_trace_cmp u_cmp (
        .addr        (s2_addr),
        .wd          (s2_wd),
        .pc          (s2_pc),
        .trace_pc    (trace_pc),
        .trace_waddr (trace_waddr),
        .trace_wdata (trace_wdata),
        .trace_end   (trace_end),
        .code        (cmp_code)
    );

    always_comb begin
        c_v         = rfw_in.wen && !(SKIP_R0 && rfw_in.addr == 5'd0);
        s2_err      = s2_v && cmp_code != CHK_NONE;
        late_commit = c_v && (state == ST_FIN_RD || state == ST_FIN_CMP || (state == ST_RUN && idx == IDX_MAX));
        s1_take     = state == ST_RUN && c_v && !s2_err && !late_commit;
        fin_rd      = state == ST_FIN_RD && !s2_v && !c_v;
        trace_ren   = reset && (s1_take || fin_rd);
        trace_raddr = reset ? idx : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_RUN;
            idx        <= '0;
            s2_v       <= 1'b0;
            s2_idx     <= '0;
            s2_addr    <= '0;
            s2_wd      <= '0;
            s2_pc      <= '0;
            chk_pass   <= 1'b0;
            chk_fail   <= 1'b0;
            fail_code  <= CHK_NONE;
            fail_idx   <= '0;
            fail_pc    <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
            commit_cnt <= '0;
        end else begin
            s2_v <= 1'b0;
            if (s2_v && !s2_err && commit_cnt != '1)
                commit_cnt <= commit_cnt + 32'd1;
            // S2 errors outrank anything seen at S1 or by the finish sequence
            if (s2_err) begin
                state     <= ST_FAIL;
                chk_fail  <= 1'b1;
                fail_code <= cmp_code;
                fail_idx  <= s2_idx;
                fail_pc   <= s2_pc;
                fail_exp  <= trace_wdata;
                fail_got  <= s2_wd;
            end else if (late_commit) begin
                state     <= ST_FAIL;
                chk_fail  <= 1'b1;
                fail_code <= CHK_OVERRUN;
                fail_idx  <= idx;
                fail_pc   <= pc_in;
                fail_exp  <= '0;
                fail_got  <= rfw_in.wd;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (c_v) begin
                            s2_v    <= 1'b1;
                            s2_idx  <= idx;
                            s2_addr <= rfw_in.addr;
                            s2_wd   <= rfw_in.wd;
                            s2_pc   <= pc_in;
                            idx     <= idx + 1'b1;
                        end
                        if (finish)
                            state <= ST_FIN_RD;
                    end
                    ST_FIN_RD: begin
                        if (!s2_v)
                            state <= ST_FIN_CMP;
                    end
                    ST_FIN_CMP: begin
                        if (trace_end) begin
                            state    <= ST_DONE;
                            chk_pass <= 1'b1;
                        end else begin
                            state     <= ST_FAIL;
                            chk_fail  <= 1'b1;
                            fail_code <= CHK_UNDERRUN;
                            fail_idx  <= idx;
                            fail_pc   <= '0;
                            fail_exp  <= trace_wdata;
                            fail_got  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rfwrite_trace_checker.sv
// tb_rfwrite_trace_checker: directed self-checking bench for rfwrite_trace_checker.
module tb_rfwrite_trace_checker;
    import rfwrite_trace_checker_pkg::*;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    rf_w_t         rfw_in = '0;
    word_t         pc_in = '0;
    logic          finish = 1'b0;
    logic          trace_ren;
    logic [AW-1:0] trace_raddr;
    word_t         trace_pc = '0;
    logic [4:0]    trace_waddr = '0;
    word_t         trace_wdata = '0;
    logic          trace_end = 1'b0;
    logic          chk_pass, chk_fail;
    chk_fail_t     fail_code;
    logic [AW-1:0] fail_idx;
    word_t         fail_pc, fail_exp, fail_got, commit_cnt;

    word_t      mpc [16];
    logic [4:0] maddr [16];
    word_t      mwd [16];
    logic       mend [16];

    int total = 0;
    int passed = 0;

    rfwrite_trace_checker #(.TRACE_AW(AW)) dut (
        .clk(clk), .reset(reset), .rfw_in(rfw_in), .pc_in(pc_in), .finish(finish),
        .trace_ren(trace_ren), .trace_raddr(trace_raddr),
        .trace_pc(trace_pc), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata), .trace_end(trace_end),
        .chk_pass(chk_pass), .chk_fail(chk_fail), .fail_code(fail_code), .fail_idx(fail_idx),
        .fail_pc(fail_pc), .fail_exp(fail_exp), .fail_got(fail_got), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (trace_ren) begin
            trace_pc    <= mpc[trace_raddr];
            trace_waddr <= maddr[trace_raddr];
            trace_wdata <= mwd[trace_raddr];
            trace_end   <= mend[trace_raddr];
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic wen, input logic [4:0] addr, input word_t wd, input word_t pc, input logic fin);
        rfw_in = '{wen: wen, addr: addr, wd: wd};
        pc_in  = pc;
        finish = fin;
        #1;
    endtask

    task automatic idle();
        put(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic load_pass();
        for (int i = 0; i < 16; i++) begin
            mpc[i] = 32'h0; maddr[i] = 5'd0; mwd[i] = 32'h0; mend[i] = 1'b1;
        end
        mpc[0] = 32'hBFC0_0000; maddr[0] = 5'd8;  mwd[0] = 32'h1111; mend[0] = 1'b0;
        mpc[1] = 32'hBFC0_0004; maddr[1] = 5'd9;  mwd[1] = 32'h1235; mend[1] = 1'b0;
        mpc[2] = 32'hBFC0_0008; maddr[2] = 5'd10; mwd[2] = 32'h3333; mend[2] = 1'b0;
    endtask

    task automatic c0(input logic fin); put(1'b1, 5'd8,  32'h1111, 32'hBFC0_0000, fin); endtask
    task automatic c1(input logic fin); put(1'b1, 5'd9,  32'h1235, 32'hBFC0_0004, fin); endtask
    task automatic c2(input logic fin); put(1'b1, 5'd10, 32'h3333, 32'hBFC0_0008, fin); endtask

    task automatic test_reset();
        do_reset();
        idle();
        total++; if ({chk_pass, chk_fail, trace_ren} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {chk_pass, chk_fail, trace_ren}); else passed++;
        total++; if (fail_code !== CHK_NONE || fail_idx !== 4'd0 || fail_pc !== 32'h0) $display("FAIL reset_fail code=%0d idx=%0d pc=%h exp=0", fail_code, fail_idx, fail_pc); else passed++;
        total++; if (fail_exp !== 32'h0 || fail_got !== 32'h0 || commit_cnt !== 32'h0) $display("FAIL reset_data exp=%h got=%h cnt=%0d required 0", fail_exp, fail_got, commit_cnt); else passed++;
    endtask

    task automatic test_pass();
        load_pass();
        do_reset();
        c0(1'b0);
        total++; if (trace_ren !== 1'b1 || trace_raddr !== 4'd0) $display("FAIL pass_rd0 ren=%b addr=%0d exp 1/0", trace_ren, trace_raddr); else passed++;
        step();
        c1(1'b0);
        total++; if (trace_ren !== 1'b1 || trace_raddr !== 4'd1) $display("FAIL pass_rd1 ren=%b addr=%0d exp 1/1", trace_ren, trace_raddr); else passed++;
        step();
        c2(1'b0);
        total++; if (trace_ren !== 1'b1 || trace_raddr !== 4'd2) $display("FAIL pass_rd2 ren=%b addr=%0d exp 1/2", trace_ren, trace_raddr); else passed++;
        step();
        put(1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        step();
        idle();
        total++; if (trace_ren !== 1'b1 || trace_raddr !== 4'd3 || chk_pass !== 1'b0) $display("FAIL pass_sentinel_rd ren=%b addr=%0d pass=%b exp 1/3/0", trace_ren, trace_raddr, chk_pass); else passed++;
        step();
        total++; if (chk_pass !== 1'b0) $display("FAIL pass_early got=%b exp=0", chk_pass); else passed++;
        step();
        total++; if (chk_pass !== 1'b1 || chk_fail !== 1'b0 || commit_cnt !== 32'd3) $display("FAIL pass_done pass=%b fail=%b cnt=%0d exp 1/0/3", chk_pass, chk_fail, commit_cnt); else passed++;
    endtask

    task automatic test_data_fail();
        load_pass();
        do_reset();
        c0(1'b0); step();
        put(1'b1, 5'd9, 32'h1234, 32'hBFC0_0004, 1'b0); step();
        c2(1'b0); step();
        idle(); step();
        total++; if (chk_fail !== 1'b1 || fail_code !== CHK_DATA || fail_idx !== 4'd1) $display("FAIL data_code fail=%b code=%0d idx=%0d exp 1/3/1", chk_fail, fail_code, fail_idx); else passed++;
        total++; if (fail_exp !== 32'h1235 || fail_got !== 32'h1234 || fail_pc !== 32'hBFC0_0004) $display("FAIL data_vals exp=%h got=%h pc=%h req 1235/1234/bfc00004", fail_exp, fail_got, fail_pc); else passed++;
        total++; if (commit_cnt !== 32'd1) $display("FAIL data_cnt got=%0d exp=1", commit_cnt); else passed++;
        c0(1'b1);
        total++; if (trace_ren !== 1'b0) $display("FAIL fail_no_read got=%b exp=0", trace_ren); else passed++;
        step(); step();
        total++; if (fail_code !== CHK_DATA || commit_cnt !== 32'd1 || chk_pass !== 1'b0) $display("FAIL fail_held code=%0d cnt=%0d pass=%b exp 3/1/0", fail_code, commit_cnt, chk_pass); else passed++;
        idle();
    endtask

    task automatic test_reset_from_fail();
        reset = 1'b0;
        step();
        total++; if (chk_fail !== 1'b0 || fail_code !== CHK_NONE || fail_got !== 32'h0 || commit_cnt !== 32'h0) $display("FAIL rst_fail fail=%b code=%0d got=%h cnt=%0d exp 0", chk_fail, fail_code, fail_got, commit_cnt); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_pc_fail();
        load_pass();
        do_reset();
        put(1'b1, 5'd5, 32'h1111, 32'hBFC0_0010, 1'b0); step();
        idle(); step();
        total++; if (fail_code !== CHK_PC || fail_idx !== 4'd0 || fail_pc !== 32'hBFC0_0010) $display("FAIL pc_wins code=%0d idx=%0d pc=%h exp 1/0/bfc00010", fail_code, fail_idx, fail_pc); else passed++;
    endtask

    task automatic test_reg_fail();
        load_pass();
        do_reset();
        put(1'b1, 5'd7, 32'h1111, 32'hBFC0_0000, 1'b0); step();
        idle(); step();
        total++; if (fail_code !== CHK_REG || commit_cnt !== 32'd0) $display("FAIL reg code=%0d cnt=%0d exp 2/0", fail_code, commit_cnt); else passed++;
    endtask

    task automatic test_overrun();
        load_pass();
        do_reset();
        c0(1'b0); step(); c1(1'b0); step(); c2(1'b0); step();
        put(1'b1, 5'd11, 32'h4444, 32'hBFC0_000C, 1'b0); step();
        idle(); step();
        total++; if (fail_code !== CHK_OVERRUN || fail_idx !== 4'd3 || fail_pc !== 32'hBFC0_000C || commit_cnt !== 32'd3) $display("FAIL overrun code=%0d idx=%0d pc=%h cnt=%0d exp 4/3/bfc0000c/3", fail_code, fail_idx, fail_pc, commit_cnt); else passed++;
    endtask

    task automatic test_underrun();
        load_pass();
        do_reset();
        c0(1'b0); step(); c1(1'b0); step();
        put(1'b0, 5'd0, 32'h0, 32'h0, 1'b1); step();
        idle(); step(); step(); step();
        total++; if (fail_code !== CHK_UNDERRUN || fail_idx !== 4'd2 || fail_pc !== 32'h0 || chk_pass !== 1'b0 || commit_cnt !== 32'd2) $display("FAIL underrun code=%0d idx=%0d pc=%h pass=%b cnt=%0d exp 5/2/0/0/2", fail_code, fail_idx, fail_pc, chk_pass, commit_cnt); else passed++;
    endtask

    task automatic test_late_commit();
        load_pass();
        do_reset();
        c0(1'b0); step(); c1(1'b0); step(); c2(1'b0); step();
        put(1'b0, 5'd0, 32'h0, 32'h0, 1'b1); step();
        put(1'b1, 5'd12, 32'h5555, 32'hBFC0_0020, 1'b0); step();
        idle(); step();
        total++; if (fail_code !== CHK_OVERRUN || fail_pc !== 32'hBFC0_0020 || fail_idx !== 4'd3) $display("FAIL late_commit code=%0d pc=%h idx=%0d exp 4/bfc00020/3", fail_code, fail_pc, fail_idx); else passed++;
    endtask

    task automatic test_commit_with_finish();
        load_pass();
        do_reset();
        c0(1'b0); step(); c1(1'b0); step(); c2(1'b1); step();
        idle();
        for (int i = 0; i < 10 && !(chk_pass || chk_fail); i++) step();
        total++; if (chk_pass !== 1'b1 || chk_fail !== 1'b0 || commit_cnt !== 32'd3) $display("FAIL fin_commit pass=%b fail=%b cnt=%0d exp 1/0/3", chk_pass, chk_fail, commit_cnt); else passed++;
    endtask

`ifdef RFW_CHECK_SKIP_R0_EN
    task automatic test_skip_r0();
        load_pass();
        do_reset();
        c0(1'b0); step();
        put(1'b1, 5'd0, 32'hDEAD, 32'hBFC0_0100, 1'b0);
        total++; if (trace_ren !== 1'b0) $display("FAIL r0_no_read got=%b exp=0", trace_ren); else passed++;
        step();
        c1(1'b0); step();
        put(1'b1, 5'd0, 32'hBEEF, 32'hBFC0_0104, 1'b0); step();
        c2(1'b1); step();
        idle();
        for (int i = 0; i < 10 && !(chk_pass || chk_fail); i++) step();
        total++; if (chk_pass !== 1'b1 || commit_cnt !== 32'd3) $display("FAIL r0_pass pass=%b cnt=%0d exp 1/3", chk_pass, commit_cnt); else passed++;
    endtask
`endif

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            mpc[i] = 32'h100 + 32'(4 * i); maddr[i] = 5'(i + 1); mwd[i] = 32'(3 * i + 7); mend[i] = 1'b0;
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 5'(i + 1), 32'(3 * i + 7), 32'h100 + 32'(4 * i), 1'b0);
            step();
        end
        idle(); step();
        total++; if (fail_code !== CHK_OVERRUN || fail_idx !== 4'd15 || fail_pc !== 32'h13C || commit_cnt !== 32'd15) $display("FAIL wrap code=%0d idx=%0d pc=%h cnt=%0d exp 4/15/13c/15", fail_code, fail_idx, fail_pc, commit_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        load_pass();
        do_reset();
        c0(1'b0); step(); c1(1'b0);
        reset = 1'b0;
        #1;
        total++; if (trace_ren !== 1'b0) $display("FAIL mid_ren got=%b exp=0", trace_ren); else passed++;
        step();
        total++; if (commit_cnt !== 32'd0 || chk_fail !== 1'b0 || chk_pass !== 1'b0 || trace_raddr !== 4'd0) $display("FAIL mid_reset cnt=%0d fail=%b pass=%b addr=%0d exp 0", commit_cnt, chk_fail, chk_pass, trace_raddr); else passed++;
        reset = 1'b1;
        idle();
        test_pass();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_data_fail();
        test_reset_from_fail();
        test_pc_fail();
        test_reg_fail();
        test_overrun();
        test_underrun();
        test_late_commit();
        test_commit_with_finish();
`ifdef RFW_CHECK_SKIP_R0_EN
        test_skip_r0();
`endif
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
